fsm_table_engine: RTL

- Generalised, table-driven Mealy/Moore state machine engine. Replaces hand-coded fixed six-state, one-bit-input FSMs.
- Next-state and output tables are held in registers and can be rewritten at run time through a config port.
- Sits between a control input bus and a decision output, with an error flag and a state observation port for debug.

---
 rtl/fsm_tbl_pkg.sv | 42 ++++
 rtl/fsm_tbl_mem.sv | 65 ++++++
 rtl/fsm_table_engine.sv | 103 ++++++++++
 3 files changed

// File: rtl/fsm_tbl_pkg.sv
// rtl/fsm_tbl_pkg.sv - shared types, default table and helpers for the table-driven FSM engine
package fsm_tbl_pkg;

  localparam int NEXT_MAX_W = 6;
  localparam int OUT_MAX_W  = 8;

  // Entries are stored at the widest legal size; instances truncate on read.
  typedef struct packed {
    logic [NEXT_MAX_W-1:0] next;
    logic [OUT_MAX_W-1:0]  out;
  } tbl_entry_t;

  localparam logic [2:0] DEF_NEXT [6][2] = '{
    '{3'd4, 3'd3}, '{3'd5, 3'd3}, '{3'd4, 3'd1},
    '{3'd5, 3'd1}, '{3'd2, 3'd5}, '{3'd1, 3'd2}
  };

  localparam logic DEF_OUT [6][2] = '{
    '{1'b0, 1'b1}, '{1'b0, 1'b0}, '{1'b0, 1'b1},
    '{1'b0, 1'b0}, '{1'b0, 1'b1}, '{1'b0, 1'b0}
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic tbl_entry_t def_entry(input int s, input int i, input bit use_def,
                                           input int init_state);
    tbl_entry_t e;
    e.next = NEXT_MAX_W'(init_state);
    e.out  = '0;
    if (use_def && (s < 6) && (i < 2)) begin
      e.next = NEXT_MAX_W'(DEF_NEXT[s[2:0]][i[0]]);
      e.out  = OUT_MAX_W'(DEF_OUT[s[2:0]][i[0]]);
    end
    return e;
  endfunction

endpackage

// File: rtl/fsm_tbl_mem.sv
// rtl/fsm_tbl_mem.sv - next-state/output table registers with validated write port and one read port
module fsm_tbl_mem
  import fsm_tbl_pkg::*;
#(
  parameter int NUM_STATES = 6,
  parameter int IN_W       = 1,
  parameter int OUT_W      = 1,
  parameter int INIT_STATE = 0,
  parameter int STATE_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [STATE_W-1:0] i_wr_state,
  input  logic [IN_W-1:0]    i_wr_in,
  input  logic [STATE_W-1:0] i_wr_next,
  input  logic [OUT_W-1:0]   i_wr_out,
  output logic               o_wr_err,
  input  logic [STATE_W-1:0] i_rd_state,
  input  logic [IN_W-1:0]    i_rd_in,
  output logic               o_rd_legal,
  output tbl_entry_t         o_rd
);

  localparam int NUM_IN  = 1 << IN_W;
  localparam bit USE_DEF = (NUM_STATES == 6) && (IN_W == 1) && (OUT_W == 1);

  tbl_entry_t r_tbl [NUM_STATES][NUM_IN];
  logic       r_wr_err;
  logic       w_wr_ok;
  logic       w_rd_legal;
  tbl_entry_t w_wr;

  function automatic logic below_num(input logic [STATE_W-1:0] s);
    return {1'b0, s} < (STATE_W+1)'(NUM_STATES);
  endfunction

  assign w_wr_ok    = below_num(i_wr_state) && below_num(i_wr_next);
  assign w_wr       = '{next: NEXT_MAX_W'(i_wr_next), out: OUT_MAX_W'(i_wr_out)};
  assign w_rd_legal = below_num(i_rd_state);

  // Async reset also discards any write landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_err <= 1'b0;
      for (int s = 0; s < NUM_STATES; s++)
        for (int i = 0; i < NUM_IN; i++)
          r_tbl[s][i] <= def_entry(s, i, USE_DEF, INIT_STATE);
    end else begin
      r_wr_err <= i_we && !w_wr_ok;
      if (i_we && w_wr_ok)
        r_tbl[i_wr_state][i_wr_in] <= w_wr;
    end
  end

  always_comb begin
    o_rd = '0;
    if (w_rd_legal)
      o_rd = r_tbl[i_rd_state][i_rd_in];
  end

  assign o_rd_legal = w_rd_legal;
  assign o_wr_err   = r_wr_err;

endmodule

// File: rtl/fsm_table_engine.sv
// rtl/fsm_table_engine.sv - run-time programmable Mealy/Moore state machine engine
module fsm_table_engine
  import fsm_tbl_pkg::*;
#(
  parameter  int NUM_STATES = 6,
  parameter  int IN_W       = 1,
  parameter  int OUT_W      = 1,
  parameter  int INIT_STATE = 0,
  parameter  int REG_OUT    = 0,
  localparam int STATE_W    = clog2(NUM_STATES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sync_clr,
  input  logic [IN_W-1:0]    x,
  output logic [OUT_W-1:0]   y,
  output logic [STATE_W-1:0] state_o,
  output logic               step_o,
  input  logic               cfg_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [IN_W-1:0]    cfg_in,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic [OUT_W-1:0]   cfg_out,
  output logic               cfg_err,
  output logic               err
);

  localparam logic [STATE_W-1:0] INIT = STATE_W'(INIT_STATE);

  logic [STATE_W-1:0] r_state, w_state_nxt;
  logic [OUT_W-1:0]   r_y, w_y_nxt, w_y_comb;
  logic               r_step, w_step_nxt;
  logic               r_err, w_err_nxt;
  logic               w_legal;
  tbl_entry_t         w_rd;

  fsm_tbl_mem #(
    .NUM_STATES (NUM_STATES),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .INIT_STATE (INIT_STATE),
    .STATE_W    (STATE_W)
  ) u_mem (
    .clk        (clk),
    .reset      (reset),
    .i_we       (cfg_we),
    .i_wr_state (cfg_state),
    .i_wr_in    (cfg_in),
    .i_wr_next  (cfg_next),
    .i_wr_out   (cfg_out),
    .o_wr_err   (cfg_err),
    .i_rd_state (r_state),
    .i_rd_in    (x),
    .o_rd_legal (w_legal),
    .o_rd       (w_rd)
  );

  // The table read returns zero for an illegal state, so y is forced low there.
  assign w_y_comb = OUT_W'(w_rd.out);

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_err_nxt   = r_err;
    w_step_nxt  = 1'b0;
    if (sync_clr) begin
      w_state_nxt = INIT;
      w_y_nxt     = '0;
      w_err_nxt   = 1'b0;
    end else if (en) begin
      w_step_nxt = 1'b1;
      if (w_legal) begin
        w_state_nxt = STATE_W'(w_rd.next);
        w_y_nxt     = w_y_comb;
      end else begin
        w_state_nxt = INIT;
        w_y_nxt     = '0;
        w_err_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_y     <= '0;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_step  <= w_step_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign y       = (REG_OUT != 0) ? r_y : w_y_comb;
  assign state_o = r_state;
  assign step_o  = r_step;
  assign err     = r_err;

endmodule
